// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing, datapath strobes, retired counter.
// Optional build macro MC_MEM_WAIT_EN stalls FETCH and MEM on the mem_ready handshake.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic [2:0]  aluop,
  output logic        pc_we,
  output logic        ir_we,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        reg_we,
  output logic [1:0]  pc_src,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  localparam logic [3:0] OP_R    = 4'b0000;
  localparam logic [3:0] OP_LW   = 4'b0001;
  localparam logic [3:0] OP_SW   = 4'b0010;
  localparam logic [3:0] OP_BEQ  = 4'b0011;
  localparam logic [3:0] OP_JMP  = 4'b0100;
  localparam logic [3:0] OP_HALT = 4'b1111;

  state_t      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [15:0] retired_q, retired_d;
  logic        mem_ok_s;
  logic        retire_s;

`ifdef MC_MEM_WAIT_EN
  assign mem_ok_s = mem_ready;
`else
  logic mem_ready_unused;
  assign mem_ready_unused = mem_ready;
  assign mem_ok_s = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= 4'b0000;
      retired_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
        else       state_d = S_IDLE;
      end
      S_FETCH: begin
        if (mem_ok_s) state_d = S_DECODE;
        else          state_d = S_FETCH;
      end
      S_DECODE: begin
        case (opcode)
          OP_R, OP_LW, OP_SW, OP_BEQ: state_d = S_EXEC;
          OP_HALT:                    state_d = S_IDLE;
          default:                    state_d = S_FETCH;
        endcase
      end
      S_EXEC: begin
        case (op_q)
          OP_R:         state_d = S_WB;
          OP_LW, OP_SW: state_d = S_MEM;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (!mem_ok_s)          state_d = S_MEM;
        else if (op_q == OP_LW) state_d = S_WB;
        else                    state_d = S_FETCH;
      end
      S_WB:    state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  // The instruction completes on the edge that leaves its final state; illegal and HALT never count.
  always_comb begin
    retire_s = 1'b0;
    case (state_q)
      S_DECODE: retire_s = (opcode == OP_JMP);
      S_EXEC:   retire_s = (op_q == OP_BEQ);
      S_MEM:    retire_s = mem_ok_s && (op_q == OP_SW);
      S_WB:     retire_s = 1'b1;
      default:  retire_s = 1'b0;
    endcase
    op_d = (state_q == S_DECODE) ? opcode : op_q;
    if (retire_s) retired_d = retired_q + 16'd1;
    else          retired_d = retired_q;
  end

  always_comb begin
    aluop  = 3'b000;
    pc_we  = 1'b0;
    ir_we  = 1'b0;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    reg_we = 1'b0;
    pc_src = 2'b00;
    done   = 1'b0;
    err    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_rd = 1'b1;
        ir_we  = mem_ok_s;
        pc_we  = mem_ok_s;
        aluop  = 3'b001;
      end
      S_DECODE: begin
        case (opcode)
          OP_R, OP_LW, OP_SW, OP_BEQ: err = 1'b0;
          OP_JMP: begin
            pc_we  = 1'b1;
            pc_src = 2'b10;
          end
          OP_HALT: done = 1'b1;
          default: err  = 1'b1;
        endcase
      end
      S_EXEC: begin
        case (op_q)
          OP_R:         aluop = 3'b100;
          OP_LW, OP_SW: aluop = 3'b001;
          OP_BEQ: begin
            aluop  = 3'b010;
            pc_we  = zero;
            pc_src = 2'b01;
          end
          default:      aluop = 3'b000;
        endcase
      end
      S_MEM: begin
        if (op_q == OP_LW) mem_rd = 1'b1;
        else               mem_wr = 1'b1;
      end
      S_WB:    reg_we = 1'b1;
      default: aluop  = 3'b000;
    endcase
  end

  assign busy    = (state_q != S_IDLE);
  assign retired = retired_q;

endmodule
